// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode seven-segment scanner for the BCDConverter digit bus.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_SCANNER_LZB_EN.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [43:0]           bcd_in,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {SHOW, GAP} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              idx_q;
  logic [43:0]             shadow_q;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    ovf_q;

  logic [3:0]              dig [11];
  logic                    cnt_wrap;
  logic [3:0]              idx_d;
  logic [6:0]              seg_d;
  logic                    ovf_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 11; i++) begin
      dig[i] = shadow_q[4*i +: 4];
    end
  end

  // Hidden digits (positions NUM_DIGITS..10) feed the overflow flag only.
  always_comb begin
    ovf_d = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i >= NUM_DIGITS && dig[i] != 4'd0) begin
        ovf_d = 1'b1;
      end
    end
  end

  assign cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign idx_d    = (idx_q == 4'(NUM_DIGITS - 1)) ? 4'd0 : idx_q + 4'd1;

`ifdef BCD_DISPLAY_SCANNER_LZB_EN
  logic [10:0] blank;
  logic        zero_run;

  // A visible digit blanks only if it and every visible digit above it are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      if (i < NUM_DIGITS) begin
        zero_run = zero_run && (dig[i] == 4'd0);
        blank[i] = zero_run && (i != 0);
      end
    end
  end

  assign seg_d = blank[idx_q] ? 7'h7F : seg_decode(dig[idx_q]);
`else
  assign seg_d = seg_decode(dig[idx_q]);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (enable) begin
      shadow_q <= bcd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      // GAP blanks all anodes for one cycle; seg keeps its last value.
      if (state_q == GAP) begin
        an_q <= '1;
      end else begin
        an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        seg_q <= seg_d;
      end
      if (cnt_wrap) begin
        cnt_q   <= '0;
        idx_q   <= idx_d;
        state_q <= GAP;
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
        state_q <= SHOW;
      end
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign overflow = ovf_q;

endmodule
